mdu_iterative: RTL and testbench

- Parametrised multiply/divide unit owning the HI/LO register pair. It is the next generation of the execute-stage mult/div logic.
- Replaces single-cycle arithmetic with fixed busy counters by true iterative datapaths:
  - shift-add multiplier retiring MUL_STEP bits per cycle;
  - restoring divider retiring one quotient bit per cycle.
- Adds MADD/MSUB accumulate, defined divide-by-zero results, a cancel input for pipeline flushes, and a done pulse.
- Sits beside the ALU in EX. The hazard unit stalls on busy.

---
 rtl/mdu_iterative.sv | 220 ++++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO.
// Shift-add multiplier, restoring divider, MADD/MSUB accumulate, flush cancel.
module mdu_iterative #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W    = WIDTH;
  localparam int MCYC = WIDTH / MUL_STEP;
  localparam int CW   = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]  cnt;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [W-1:0]   dvsr;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   a_raw;
  logic [2:0]     opq;
  logic           neg;
  logic           rneg;
  logic           dz;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;

  logic           accept;
  logic           is_mul;
  logic           is_div;
  logic           is_mthi;
  logic           is_mtlo;
  logic           sgn;
  logic [W-1:0]   a_abs;
  logic [W-1:0]   b_abs;

  assign accept  = start && !cancel && (state == IDLE);
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU) ||
                   (op == OP_MADD) || (op == OP_MSUB);
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign is_mthi = (op == OP_MTHI);
  assign is_mtlo = (op == OP_MTLO);
  assign sgn     = (op != OP_MULTU) && (op != OP_DIVU);
  assign a_abs   = (sgn && a[W-1]) ? -a : a;
  assign b_abs   = (sgn && b[W-1]) ? -b : b;

  // Multiplier step: MUL_STEP partial products per cycle
  logic [2*W-1:0] step_sum;
  always_comb begin
    step_sum = acc;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier[j]) step_sum = step_sum + (mcand << j);
    end
  end

  // Restoring divider step
  logic [W:0]   shifted;
  logic [W:0]   trial;
  logic         qbit;
  logic [W-1:0] rem_nx;
  logic [W-1:0] quo_nx;

  assign shifted = {rem, quo[W-1]};
  assign trial   = shifted - {1'b0, dvsr};
  assign qbit    = !trial[W];
  assign rem_nx  = qbit ? trial[W-1:0] : shifted[W-1:0];
  assign quo_nx  = {quo[W-2:0], qbit};

  // Sign fix-up and accumulate
  logic [2*W-1:0] prod;
  logic [2*W-1:0] hilo;
  logic [2*W-1:0] mul_res;
  logic [2*W-1:0] div_res;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;
  logic           opq_div;

  assign prod    = neg ? -acc : acc;
  assign hilo    = {hi_q, lo_q};
  assign q_fix   = neg ? -quo : quo;
  assign r_fix   = rneg ? -rem : rem;
  assign opq_div = (opq == OP_DIV) || (opq == OP_DIVU);

  always_comb begin
    mul_res = prod;
    if (opq == OP_MADD) mul_res = hilo + prod;
    else if (opq == OP_MSUB) mul_res = hilo - prod;
  end

  always_comb begin
    div_res = {r_fix, q_fix};
    if (dz) div_res = {a_raw, {W{1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && is_mul) state_nx = MUL;
        else if (accept && is_div) state_nx = DIV;
      end
      MUL, DIV: begin
        if (cancel) state_nx = IDLE;
        else if (cnt == '0) state_nx = FIX;
      end
      FIX: begin
        state_nx = IDLE;
        done     = !cancel;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      dvsr   <= '0;
      quo    <= '0;
      rem    <= '0;
      a_raw  <= '0;
      opq    <= '0;
      neg    <= 1'b0;
      rneg   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            opq <= op;
            unique case (1'b1)
              is_mthi: hi_q <= a;
              is_mtlo: lo_q <= a;
              is_mul: begin
                mcand  <= {{W{1'b0}}, a_abs};
                mplier <= b_abs;
                acc    <= '0;
                neg    <= sgn && (a[W-1] ^ b[W-1]);
                cnt    <= CW'(MCYC - 1);
              end
              is_div: begin
                quo   <= a_abs;
                dvsr  <= b_abs;
                rem   <= '0;
                neg   <= sgn && (a[W-1] ^ b[W-1]);
                rneg  <= sgn && a[W-1];
                dz    <= (b == '0);
                a_raw <= a;
                cnt   <= CW'(W - 1);
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc    <= step_sum;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt - 1'b1;
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (!cancel) begin
            if (opq_div) {hi_q, lo_q} <= div_res;
            else {hi_q, lo_q} <= mul_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative.
// Directed vectors, random ops against an arithmetic model, cancel and reset.
module tb_mdu_iterative;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mh = '0;
  logic [31:0] ml = '0;

  mdu_iterative #(.WIDTH(32), .MUL_STEP(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .cancel(cancel),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [63:0] hl);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] p;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = 64'(sx * sy);
    res = hl;
    case (o)
      3'd0: res = p;
      3'd1: res = {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
      3'd4: res = {x, hl[31:0]};
      3'd5: res = {hl[63:32], x};
      3'd6: res = hl + p;
      3'd7: res = hl - p;
      default: res = hl;
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [2:0] o);
    if (o == 3'd2 || o == 3'd3) return 33;
    if (o == 3'd4 || o == 3'd5) return 0;
    return 9;
  endfunction

  // Issues one command, scrambles operands after acceptance, waits for idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int lat,
                        output int dones, output int partial);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = hi;
    l0 = lo;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    dones = 0;
    partial = 0;
    while (busy && lat < 100) begin
      @(negedge clk);
      if (done) dones++;
      if (hi !== h0 || lo !== l0) partial++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    cancel = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (hi !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hi got %h want 0", hi);
    end
    n_checks++;
    if (lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_lo got %h want 0", lo);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got %b want 0", done);
    end
    @(negedge clk);
    reset = 1'b0;
    mh = '0;
    ml = '0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [9];
    logic [31:0] t_a  [9];
    logic [31:0] t_b  [9];
    logic [31:0] t_hi [9];
    logic [31:0] t_lo [9];
    int lat;
    int dn;
    int pt;
    int el;
    t_op = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
    t_a  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h7,
             32'h12345678, 32'h1, 32'h2, 32'h1, 32'h80000000};
    t_b  = '{32'h3, 32'hFFFFFFFF, 32'h2, 32'h0,
             32'h0, 32'h0, 32'h3, 32'h8, 32'hFFFFFFFF};
    t_hi = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h7,
             32'h12345678, 32'h12345678, 32'h12345678, 32'h12345677,
             32'h0};
    t_lo = '{32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'h1, 32'h7, 32'hFFFFFFFF, 32'h80000000};
    for (int i = 0; i < 9; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat, dn, pt);
      el = exp_lat(t_op[i]);
      n_checks++;
      if (hi !== t_hi[i] || lo !== t_lo[i]) begin
        n_fail++;
        $display("FAIL dir%0d_hilo got %h_%h want %h_%h",
                 i, hi, lo, t_hi[i], t_lo[i]);
      end
      n_checks++;
      if (lat !== el) begin
        n_fail++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, el);
      end
      n_checks++;
      if (dn !== ((el == 0) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL dir%0d_done got %0d want %0d",
                 i, dn, (el == 0) ? 0 : 1);
      end
      n_checks++;
      if (pt !== 0) begin
        n_fail++;
        $display("FAIL dir%0d_partial got %0d want 0", i, pt);
      end
    end
    {mh, ml} = {hi, lo};
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] e;
    int lat;
    int dn;
    int pt;
    int el;
    for (int i = 0; i < 48; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = '0;
      if ($urandom_range(0, 5) == 0) x = 32'($urandom_range(0, 40)) - 32'd20;
      if ($urandom_range(0, 5) == 0) y = 32'($urandom_range(0, 10)) - 32'd5;
      e = model(o, x, y, {mh, ml});
      run_op(o, x, y, lat, dn, pt);
      el = exp_lat(o);
      n_checks++;
      if ({hi, lo} !== e) begin
        n_fail++;
        $display("FAIL rnd%0d_op%0d a=%h b=%h got %h_%h want %h",
                 i, o, x, y, hi, lo, e);
      end
      n_checks++;
      if (lat !== el || dn !== ((el == 0) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL rnd%0d_timing lat %0d done %0d want lat %0d",
                 i, lat, dn, el);
      end
      {mh, ml} = e;
    end
  endtask

  task automatic test_cancel();
    int seen;
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    op = 3'd2;
    a = 32'h1234;
    b = 32'h7;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start = (i == 4);
      op = 3'd4;
      a = 32'hDEADBEEF;
      if (done) seen++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    if (done) seen++;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_busy got %b want 0", busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (hi !== mh || lo !== ml) begin
      n_fail++;
      $display("FAIL cancel_hilo got %h_%h want %h_%h", hi, lo, mh, ml);
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL cancel_done got %0d want 0", seen);
    end

    @(negedge clk);
    start = 1'b1;
    op = 3'd0;
    a = 32'h5;
    b = 32'h9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fixcancel_done got done %b busy %b want 0 1", done, busy);
    end
    @(posedge clk);
    #1;
    cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== mh || lo !== ml) begin
      n_fail++;
      $display("FAIL fixcancel_hilo got %h_%h busy %b want %h_%h",
               hi, lo, busy, mh, ml);
    end

    @(negedge clk);
    start = 1'b1;
    cancel = 1'b1;
    op = 3'd4;
    a = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    op = 3'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    cancel = 1'b0;
    n_checks++;
    if (hi !== mh || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idlecancel got hi %h busy %b want %h 0", hi, busy, mh);
    end
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    n_checks++;
    if (hi !== mh || lo !== ml || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_cancel_noop got %h_%h want %h_%h", hi, lo, mh, ml);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int dn;
    int pt;
    run_op(3'd4, 32'hA5A5A5A5, 32'h0, lat, dn, pt);
    run_op(3'd5, 32'h5A5A5A5A, 32'h0, lat, dn, pt);
    @(negedge clk);
    start = 1'b1;
    op = 3'd2;
    a = 32'h100;
    b = 32'h3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
      n_fail++;
      $display("FAIL midreset got %h_%h busy %b done %b want 0", hi, lo, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, lat, dn, pt);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h80000000 || lat !== 33) begin
      n_fail++;
      $display("FAIL overflow_div got %h_%h lat %0d want 00000000_80000000 33",
               hi, lo, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
